buffer_mem_arbiter: RTL and testbench
=====================================

# buffer_mem_arbiter

Arbitrates the single-port activation/weight/result buffer SRAM between three requesters: the array result writeback (RES), the host SPI data loader (WR) and the host SPI result readback (RD). Sits between the matrix controller's datapath sequencers and the buffer memory, replacing ad-hoc muxing of write and read address/data. It provides registered memory-side signals, a fixed priority with a starvation guard for readback, and a pipelined read-return channel.

## Interface
- ADDR_SIZE, 10, buffer address width
- WORD_SIZE, 16, buffer data width
- STARVE_LIMIT, 8, cycles RD may wait before it is forced to top priority (range 1..255)

- clk  in  1  clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- res_valid  in  1  result write request
- res_ready  out  1  result write accepted this cycle
- res_addr  in  ADDR_SIZE  result write address
- res_data  in  WORD_SIZE  result write data
- wr_valid  in  1  host write request
- wr_ready  out  1  host write accepted this cycle
- wr_addr  in  ADDR_SIZE  host write address
- wr_data  in  WORD_SIZE  host write data
- rd_valid  in  1  host read request
- rd_ready  out  1  host read accepted this cycle
- rd_addr  in  ADDR_SIZE  host read address
- rd_rvalid  out  1  read data valid pulse
- rd_rdata  out  WORD_SIZE  read data
- mem_addr  out  ADDR_SIZE  SRAM address (registered)
- mem_w_data  out  WORD_SIZE  SRAM write data (registered)
- mem_w_en  out  1  SRAM write enable (registered)
- mem_r_en  out  1  SRAM read enable (registered)
- mem_r_data  in  WORD_SIZE  SRAM read data, valid one cycle after mem_r_en
- grant  out  2  last accepted requester: 0 none, 1 RES, 2 WR, 3 RD (registered)

## Operation
- A request is accepted when valid and ready are both high on a clock edge. Exactly one ready may be high per cycle; ready is combinational from the valids and starve state, and is never high without its valid.
- Normal priority: RES > WR > RD.
- Starvation guard: 8-bit starve_cnt increments each cycle with rd_valid=1 and rd_ready=0, saturating at STARVE_LIMIT. When starve_cnt==STARVE_LIMIT and rd_valid=1, priority becomes RD > RES > WR. starve_cnt clears on RD acceptance or when rd_valid=0.
- On accept the memory stage loads: mem_addr/mem_w_data from the winner; mem_w_en=1 for RES/WR, mem_r_en=1 for RD. If nothing is accepted, mem_w_en=mem_r_en=0 and mem_addr/mem_w_data hold.
- Read-return pipeline: a 1-bit flag follows mem_r_en by one cycle; when set, rd_rvalid=1 and rd_rdata=mem_r_data (registered). rd_rdata holds its value otherwise.
- Back-to-back reads are fully pipelined: one accept per cycle gives one rd_rvalid per cycle, in order. RD has no back-pressure on the return channel.
- Writes and reads to the same address in consecutive accepts resolve in accept order (write-before-read if write accepted first).

## Timing
- Reset (reset_n=0, asynchronous): mem_addr=0, mem_w_data=0, mem_w_en=0, mem_r_en=0, rd_rvalid=0, rd_rdata=0, grant=0, starve_cnt=0; readies are 0 while reset_n=0.
- Reset mid-operation discards any in-flight read; no rd_rvalid is produced for it after release.
- Accept at edge N: mem_* valid in cycle N+1; for RD, rd_rvalid/rd_rdata valid in cycle N+2.
- Simultaneous RES+WR+RD every cycle: RES wins every cycle until RD starve_cnt reaches STARVE_LIMIT, then RD wins once, counter clears.
- STARVE_LIMIT=1: RD wins every second cycle under continuous contention.
- Requesters may drop valid without acceptance; the arbiter keeps no request state besides starve_cnt.

## Test plan
- Reset check: assert reset_n=0 mid-read; all outputs 0 immediately, no rd_rvalid after release.
- Single WR addr=0x010 data=0xBEEF -> wr_ready same cycle; next cycle mem_w_en=1, mem_addr=0x010, mem_w_data=0xBEEF; grant=2.
- Read after write: WR 0x020=0x1234 then RD 0x020 next cycle -> rd_rvalid two cycles after RD accept with rd_rdata=0x1234.
- Priority: RES and WR valid together for 3 cycles -> 3 RES accepts, WR waits; then WR accepted on cycle 4.
- Starvation, STARVE_LIMIT=8, RES+RD continuously valid -> RD accepted exactly on 9th cycle, then again after 8 more RES accepts.
- Pipelined read burst of 4 addresses 0x100..0x103 preloaded with 1..4 -> rd_rvalid high 4 consecutive cycles, data 1,2,3,4 in order.

Source files
------------

// File: rtl/buffer_mem_arbiter.sv
// Arbiter for the single-port buffer SRAM. It serves three requesters: array result writeback (RES),
// host write (WR) and host readback (RD). Memory-side signals are registered, and read data returns two cycles after accept.
module buffer_mem_arbiter #(
    parameter int ADDR_SIZE    = 10,
    parameter int WORD_SIZE    = 16,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 res_valid,
    output logic                 res_ready,
    input  logic [ADDR_SIZE-1:0] res_addr,
    input  logic [WORD_SIZE-1:0] res_data,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [ADDR_SIZE-1:0] wr_addr,
    input  logic [WORD_SIZE-1:0] wr_data,
    input  logic                 rd_valid,
    output logic                 rd_ready,
    input  logic [ADDR_SIZE-1:0] rd_addr,
    output logic                 rd_rvalid,
    output logic [WORD_SIZE-1:0] rd_rdata,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_w_data,
    output logic                 mem_w_en,
    output logic                 mem_r_en,
    input  logic [WORD_SIZE-1:0] mem_r_data,
    output logic [1:0]           grant
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [7:0]           starve_cnt_reg, starve_cnt_next;
    logic                 starved;
    logic [ADDR_SIZE-1:0] mem_addr_reg;
    logic [WORD_SIZE-1:0] mem_w_data_reg;
    logic                 mem_w_en_reg, mem_r_en_reg;
    logic [1:0]           grant_reg;
    logic                 rd_pend_reg;
    logic [WORD_SIZE-1:0] rdata_hold_reg;

    // A starved reader jumps ahead of both writers; readies stay low during reset.
    always_comb begin
        starved   = rd_valid && (starve_cnt_reg == LIMIT);
        res_ready = reset_n && res_valid && !starved;
        wr_ready  = reset_n && wr_valid && !res_valid && !starved;
        rd_ready  = reset_n && rd_valid && (starved || (!res_valid && !wr_valid));
    end

    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (!rd_valid || rd_ready) begin
            starve_cnt_next = 8'd0;
        end else if (starve_cnt_reg != LIMIT) begin
            starve_cnt_next = starve_cnt_reg + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt_reg <= 8'd0;
            mem_addr_reg   <= '0;
            mem_w_data_reg <= '0;
            mem_w_en_reg   <= 1'b0;
            mem_r_en_reg   <= 1'b0;
            grant_reg      <= 2'd0;
            rd_pend_reg    <= 1'b0;
            rdata_hold_reg <= '0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
            mem_w_en_reg   <= res_ready || wr_ready;
            mem_r_en_reg   <= rd_ready;
            if (res_ready) begin
                mem_addr_reg   <= res_addr;
                mem_w_data_reg <= res_data;
                grant_reg      <= 2'd1;
            end else if (wr_ready) begin
                mem_addr_reg   <= wr_addr;
                mem_w_data_reg <= wr_data;
                grant_reg      <= 2'd2;
            end else if (rd_ready) begin
                mem_addr_reg   <= rd_addr;
                grant_reg      <= 2'd3;
            end else begin
                grant_reg      <= 2'd0;
            end
            // SRAM data appears the cycle after mem_r_en, so the return flag trails it by one.
            rd_pend_reg <= mem_r_en_reg;
            if (rd_pend_reg) begin
                rdata_hold_reg <= mem_r_data;
            end
        end
    end

    assign mem_addr   = mem_addr_reg;
    assign mem_w_data = mem_w_data_reg;
    assign mem_w_en   = mem_w_en_reg;
    assign mem_r_en   = mem_r_en_reg;
    assign grant      = grant_reg;
    assign rd_rvalid  = rd_pend_reg;
    assign rd_rdata   = rd_pend_reg ? mem_r_data : rdata_hold_reg;

endmodule

// File: tb/tb_buffer_mem_arbiter.sv
// Directed bench for buffer_mem_arbiter with a behavioural SRAM; a second instance uses STARVE_LIMIT=1.
module tb_buffer_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        res_valid = 1'b0, wr_valid = 1'b0, rd_valid = 1'b0;
    logic [9:0]  res_addr = '0, wr_addr = '0, rd_addr = '0;
    logic [15:0] res_data = '0, wr_data = '0;
    logic        res_ready, wr_ready, rd_ready, rd_rvalid, mem_w_en, mem_r_en;
    logic [15:0] rd_rdata, mem_w_data, mem_r_data;
    logic [9:0]  mem_addr;
    logic [1:0]  grant;

    logic        u1_res_ready, u1_wr_ready, u1_rd_ready, u1_rd_rvalid, u1_mem_w_en, u1_mem_r_en;
    logic [15:0] u1_rd_rdata, u1_mem_w_data;
    logic [9:0]  u1_mem_addr;
    logic [1:0]  u1_grant;

    logic [15:0] sram [0:1023];
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_w_en) sram[mem_addr] <= mem_w_data;
        if (mem_r_en) mem_r_data <= sram[mem_addr];
    end

    buffer_mem_arbiter #(.ADDR_SIZE(10), .WORD_SIZE(16), .STARVE_LIMIT(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .res_valid(res_valid), .res_ready(res_ready), .res_addr(res_addr), .res_data(res_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata),
        .mem_addr(mem_addr), .mem_w_data(mem_w_data), .mem_w_en(mem_w_en), .mem_r_en(mem_r_en),
        .mem_r_data(mem_r_data), .grant(grant)
    );

    buffer_mem_arbiter #(.ADDR_SIZE(10), .WORD_SIZE(16), .STARVE_LIMIT(1)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .res_valid(res_valid), .res_ready(u1_res_ready), .res_addr(res_addr), .res_data(res_data),
        .wr_valid(wr_valid), .wr_ready(u1_wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(u1_rd_ready), .rd_addr(rd_addr),
        .rd_rvalid(u1_rd_rvalid), .rd_rdata(u1_rd_rdata),
        .mem_addr(u1_mem_addr), .mem_w_data(u1_mem_w_data), .mem_w_en(u1_mem_w_en),
        .mem_r_en(u1_mem_r_en), .mem_r_data(16'h0000), .grant(u1_grant)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #1 reset_n = 1'b0;
        tick();
        tick();
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_w_en", 32'(mem_w_en), 32'h0);
        chk("rst_r_en", 32'(mem_r_en), 32'h0);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_rvalid", 32'(rd_rvalid), 32'h0);
        chk("rst_rdata", 32'(rd_rdata), 32'h0);
        reset_n = 1'b1;
        tick();

        // Single host write
        wr_valid = 1'b1; wr_addr = 10'h010; wr_data = 16'hBEEF;
        #1;
        chk("wr_ready", 32'(wr_ready), 32'h1);
        chk("wr_res_ready", 32'(res_ready), 32'h0);
        chk("wr_rd_ready", 32'(rd_ready), 32'h0);
        tick();
        wr_valid = 1'b0;
        chk("wr_mem_w_en", 32'(mem_w_en), 32'h1);
        chk("wr_mem_addr", 32'(mem_addr), 32'h010);
        chk("wr_mem_w_data", 32'(mem_w_data), 32'hBEEF);
        chk("wr_grant", 32'(grant), 32'h2);
        tick();
        chk("idle_grant", 32'(grant), 32'h0);
        chk("idle_w_en", 32'(mem_w_en), 32'h0);
        chk("idle_addr_hold", 32'(mem_addr), 32'h010);

        // Read after write to the same address
        wr_valid = 1'b1; wr_addr = 10'h020; wr_data = 16'h1234;
        tick();
        wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 10'h020;
        #1;
        chk("raw_rd_ready", 32'(rd_ready), 32'h1);
        tick();
        rd_valid = 1'b0;
        chk("raw_r_en", 32'(mem_r_en), 32'h1);
        chk("raw_grant", 32'(grant), 32'h3);
        chk("raw_rvalid_early", 32'(rd_rvalid), 32'h0);
        tick();
        chk("raw_rvalid", 32'(rd_rvalid), 32'h1);
        chk("raw_rdata", 32'(rd_rdata), 32'h1234);
        tick();
        chk("raw_rvalid_drop", 32'(rd_rvalid), 32'h0);
        chk("raw_rdata_hold", 32'(rd_rdata), 32'h1234);

        // RES over WR for three cycles, then WR
        wr_valid = 1'b1; wr_addr = 10'h040; wr_data = 16'h5555;
        for (int i = 0; i < 3; i++) begin
            res_valid = 1'b1; res_addr = 10'(10'h030 + i); res_data = 16'(16'hA000 + i);
            #1;
            chk("pri_res_ready", 32'(res_ready), 32'h1);
            chk("pri_wr_wait", 32'(wr_ready), 32'h0);
            tick();
            chk("pri_res_grant", 32'(grant), 32'h1);
            chk("pri_res_addr", 32'(mem_addr), 32'(10'h030 + i));
            chk("pri_res_data", 32'(mem_w_data), 32'(16'hA000 + i));
        end
        res_valid = 1'b0;
        #1;
        chk("pri_wr_ready", 32'(wr_ready), 32'h1);
        tick();
        wr_valid = 1'b0;
        chk("pri_wr_grant", 32'(grant), 32'h2);
        chk("pri_wr_addr", 32'(mem_addr), 32'h040);

        // Preload 0x100..0x103 with 1..4, then a pipelined read burst
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1; wr_addr = 10'(10'h100 + i); wr_data = 16'(i + 1);
            tick();
        end
        wr_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd_valid = 1'b1; rd_addr = 10'(10'h100 + i);
            #1;
            chk("burst_rd_ready", 32'(rd_ready), 32'h1);
            tick();
            if (i == 0) chk("burst_rvalid_lat", 32'(rd_rvalid), 32'h0);
            else begin
                chk("burst_rvalid", 32'(rd_rvalid), 32'h1);
                chk("burst_rdata", 32'(rd_rdata), 32'(i));
            end
        end
        rd_valid = 1'b0;
        tick();
        chk("burst_rvalid_last", 32'(rd_rvalid), 32'h1);
        chk("burst_rdata_last", 32'(rd_rdata), 32'h4);
        tick();
        chk("burst_rvalid_end", 32'(rd_rvalid), 32'h0);

        // Starvation: RES+RD continuously valid
        res_valid = 1'b1; res_addr = 10'h050; res_data = 16'h7777;
        rd_valid = 1'b1; rd_addr = 10'h101;
        for (int c = 1; c <= 18; c++) begin
            #1;
            chk("starve_rd_ready", 32'(rd_ready), 32'((c == 9) || (c == 18)));
            chk("starve_res_ready", 32'(res_ready), 32'(!((c == 9) || (c == 18))));
            chk("starve1_rd_ready", 32'(u1_rd_ready), 32'((c % 2) == 0));
            tick();
        end
        res_valid = 1'b0; rd_valid = 1'b0;
        tick();
        tick();
        tick();

        // Reset while a read is in flight
        rd_valid = 1'b1; rd_addr = 10'h102;
        #1;
        chk("mid_rd_ready", 32'(rd_ready), 32'h1);
        tick();
        rd_valid = 1'b0;
        chk("mid_r_en", 32'(mem_r_en), 32'h1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_r_en", 32'(mem_r_en), 32'h0);
        chk("mid_rst_addr", 32'(mem_addr), 32'h0);
        chk("mid_rst_w_data", 32'(mem_w_data), 32'h0);
        chk("mid_rst_grant", 32'(grant), 32'h0);
        chk("mid_rst_rvalid", 32'(rd_rvalid), 32'h0);
        chk("mid_rst_rdata", 32'(rd_rdata), 32'h0);
        rd_valid = 1'b1; res_valid = 1'b1;
        #1;
        chk("mid_rst_rd_ready", 32'(rd_ready), 32'h0);
        chk("mid_rst_res_ready", 32'(res_ready), 32'h0);
        rd_valid = 1'b0; res_valid = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_rvalid", 32'(rd_rvalid), 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
